// File: rtl/sector_buffer.sv
// Receive-side sector buffer for SD CMD17 reads: hunts the start token, stores the
// 512-byte payload, checks the trailing CRC16 and serves 1-cycle random byte reads.
module sector_buffer #(
    parameter int TOKEN_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       gets,
    input  logic [7:0] din,
    input  logic       rd_start,
    input  logic [8:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       rd_rdy,
    output logic       done,
    output logic       crc_ok,
    output logic       error,
    output logic       busy
);

    localparam int TW = $clog2(TOKEN_TIMEOUT + 1);

    typedef enum logic [2:0] {WAIT_TOKEN, DATA, CRC_HI, CRC_LO, DONE, ERR} state_t;

    state_t          state, state_n;
    logic [9:0]      cnt, cnt_n;
    logic [TW-1:0]   tcnt, tcnt_n;
    logic [15:0]     crc_reg, crc_n;
    logic [15:0]     rx_crc, rx_crc_n;
    logic            crc_ok_n;
    logic            ram_we;

    logic [7:0]      ram [0:511];
    logic [7:0]      rd_q_p1;
    logic            rd_vld_p1;
    logic            rd_ok_p1;

    // CRC16-CCITT (poly 0x1021, MSB first), one byte per call.
    function automatic logic [15:0] crc16_update(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        tcnt_n   = tcnt;
        crc_n    = crc_reg;
        rx_crc_n = rx_crc;
        crc_ok_n = crc_ok;
        ram_we   = 1'b0;
        if (clear) begin
            state_n  = WAIT_TOKEN;
            cnt_n    = '0;
            tcnt_n   = '0;
            crc_ok_n = 1'b0;
        end else if (gets) begin
            case (state)
                WAIT_TOKEN: begin
                    if (din == 8'hFE) begin
                        state_n = DATA;
                        cnt_n   = '0;
                        crc_n   = 16'h0000;
                    end else if (din[7:4] == 4'h0 && din[3:0] != 4'h0) begin
                        state_n = ERR;
                    end else begin
                        // Counter never wraps: ERR is entered on the step that reaches the limit.
                        tcnt_n = tcnt + TW'(1);
                        if (int'(tcnt) + 1 >= TOKEN_TIMEOUT) state_n = ERR;
                    end
                end
                DATA: begin
                    ram_we = 1'b1;
                    crc_n  = crc16_update(crc_reg, din);
                    cnt_n  = cnt + 10'd1;
                    if (cnt == 10'd511) state_n = CRC_HI;
                end
                CRC_HI: begin
                    rx_crc_n = {din, rx_crc[7:0]};
                    state_n  = CRC_LO;
                end
                CRC_LO: begin
                    rx_crc_n = {rx_crc[15:8], din};
                    crc_ok_n = ({rx_crc[15:8], din} == crc_reg);
                    state_n  = DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= WAIT_TOKEN;
            cnt     <= '0;
            tcnt    <= '0;
            crc_reg <= 16'h0000;
            rx_crc  <= 16'h0000;
            crc_ok  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            tcnt    <= tcnt_n;
            crc_reg <= crc_n;
            rx_crc  <= rx_crc_n;
            crc_ok  <= crc_ok_n;
        end
    end

    // Stage p1: dual-port RAM, write from the byte stream, synchronous read for the host.
    always_ff @(posedge clk) begin
        if (ram_we) ram[cnt[8:0]] <= din;
        if (rd_start) rd_q_p1 <= ram[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_p1 <= 1'b0;
            rd_ok_p1  <= 1'b0;
        end else begin
            rd_vld_p1 <= rd_start;
            rd_ok_p1  <= rd_start && (state == DONE);
        end
    end

    assign rd_rdy  = rd_vld_p1;
    assign rd_data = rd_ok_p1 ? rd_q_p1 : 8'h00;
    assign done    = (state == DONE);
    assign error   = (state == ERR);
    assign busy    = (state == DATA) || (state == CRC_HI) || (state == CRC_LO);

endmodule

// File: tb/tb_sector_buffer.sv
// Bench for sector_buffer: randomized byte spacing and reads against a behavioural
// model, plus literal expectations from the read-path scenarios.
module tb_sector_buffer;

    localparam int TO = 4;
    localparam int P_HUNT = 0, P_PAY = 1, P_CRC1 = 2, P_CRC2 = 3, P_DONE = 4, P_ERR = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       gets = 1'b0;
    logic [7:0] din = 8'h00;
    logic       rd_start = 1'b0;
    logic [8:0] rd_addr = 9'd0;
    logic [7:0] rd_data;
    logic       rd_rdy, done, crc_ok, error, busy;

    sector_buffer #(.TOKEN_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .clear(clear), .gets(gets), .din(din),
        .rd_start(rd_start), .rd_addr(rd_addr), .rd_data(rd_data), .rd_rdy(rd_rdy),
        .done(done), .crc_ok(crc_ok), .error(error), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural model
    int         m_phase, m_junk, m_idx;
    logic [7:0] m_mem [512];
    logic [7:0] m_rxhi;
    logic       m_ok;
    logic       exp_rv;
    logic [7:0] exp_rd;
    logic       chk_en = 1'b0;

    int c_tot = 0, c_pass = 0, l_tot = 0, l_pass = 0;

    // CRC as remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
    function automatic logic [15:0] crc_ref();
        logic [16:0] r;
        logic        b;
        r = '0;
        for (int i = 0; i < 512 * 8 + 16; i++) begin
            b = (i < 4096) ? m_mem[i / 8][7 - (i % 8)] : 1'b0;
            r = {r[15:0], b};
            if (r[16]) r = r ^ 17'h11021;
        end
        return r[15:0];
    endfunction

    task automatic model_reset();
        m_phase = P_HUNT; m_junk = 0; m_idx = 0; m_rxhi = 8'h00; m_ok = 1'b0;
        exp_rv = 1'b0; exp_rd = 8'h00;
    endtask

    task automatic model_apply(input logic g, input logic [7:0] d, input logic clr);
        if (clr) begin
            m_phase = P_HUNT; m_junk = 0; m_ok = 1'b0;
        end else if (g) begin
            case (m_phase)
                P_HUNT: begin
                    if (d == 8'hFE) begin m_phase = P_PAY; m_idx = 0; end
                    else if (d < 8'h10 && d != 8'h00) m_phase = P_ERR;
                    else begin m_junk++; if (m_junk >= TO) m_phase = P_ERR; end
                end
                P_PAY: begin
                    m_mem[m_idx] = d; m_idx++;
                    if (m_idx == 512) m_phase = P_CRC1;
                end
                P_CRC1: begin m_rxhi = d; m_phase = P_CRC2; end
                P_CRC2: begin m_ok = ({m_rxhi, d} == crc_ref()); m_phase = P_DONE; end
                default: ;
            endcase
        end
    endtask

    task automatic ccheck(input string nm, input logic [15:0] act, input logic [15:0] expv);
        c_tot++;
        if (act === expv) c_pass++;
        else $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, expv);
    endtask

    task automatic lcheck(input string nm, input logic [15:0] act, input logic [15:0] expv);
        l_tot++;
        if (act === expv) l_pass++;
        else $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, expv);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            ccheck("done",   done,   m_phase == P_DONE);
            ccheck("error",  error,  m_phase == P_ERR);
            ccheck("busy",   busy,   m_phase == P_PAY || m_phase == P_CRC1 || m_phase == P_CRC2);
            ccheck("crc_ok", crc_ok, m_phase == P_DONE && m_ok);
            ccheck("rd_rdy", rd_rdy, exp_rv);
            if (exp_rv) ccheck("rd_data", rd_data, exp_rd);
        end
    end

    // One clock: drive inputs, advance the model on the sampling edge, leave 1 time unit after it.
    task automatic cyc(input logic g, input logic [7:0] d, input logic clr,
                       input logic rs, input logic [8:0] ra);
        logic       nv;
        logic [7:0] nd;
        gets = g; din = d; clear = clr; rd_start = rs; rd_addr = ra;
        nv = rs;
        nd = (rs && m_phase == P_DONE) ? m_mem[ra] : 8'h00;
        @(posedge clk);
        model_apply(g, d, clr);
        exp_rv = nv; exp_rd = nd;
        #1;
        gets = 1'b0; clear = 1'b0; rd_start = 1'b0;
    endtask

    task automatic rcyc(input logic g, input logic [7:0] d, input logic clr);
        cyc(g, d, clr, $urandom_range(0, 3) == 0, 9'($urandom_range(0, 511)));
    endtask

    task automatic send(input logic [7:0] d);
        repeat ($urandom_range(0, 2)) rcyc(1'b0, 8'h00, 1'b0);
        rcyc(1'b1, d, 1'b0);
    endtask

    task automatic do_clear();
        rcyc(1'b0, 8'h00, 1'b1);
    endtask

    // mode: 0 all 0xFF, 1 i[7:0], 2 all 0x00, 3 random
    task automatic payload(input int mode);
        for (int i = 0; i < 512; i++) begin
            case (mode)
                0: send(8'hFF);
                1: send(i[7:0]);
                2: send(8'h00);
                default: send(8'($urandom_range(0, 255)));
            endcase
        end
    endtask

    initial begin
        int n_rd;
        logic [15:0] c;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        lcheck("reset_rd_data", rd_data, 8'h00);
        lcheck("reset_rd_rdy",  rd_rdy,  1'b0);
        lcheck("reset_done",    done,    1'b0);
        lcheck("reset_crc_ok",  crc_ok,  1'b0);
        lcheck("reset_error",   error,   1'b0);
        lcheck("reset_busy",    busy,    1'b0);
        chk_en = 1'b1;

        // All-0xFF sector with its known CRC 0x7FA1
        send(8'hFE);
        lcheck("busy_after_token", busy, 1'b1);
        payload(0);
        lcheck("model_crc_ff", crc_ref(), 16'h7FA1);
        send(8'h7F);
        lcheck("busy_crc_hi", busy, 1'b1);
        send(8'hA1);
        lcheck("t1_done", done, 1'b1);
        lcheck("t1_crc_ok", crc_ok, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 9'd0);
        lcheck("t1_rd0", {rd_rdy, rd_data}, {1'b1, 8'hFF});
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 9'd511);
        lcheck("t1_rd511", {rd_rdy, rd_data}, {1'b1, 8'hFF});

        // Counting payload, wrong CRC
        do_clear();
        repeat (3) send(8'hFF);
        send(8'hFE);
        payload(1);
        send(8'h00);
        send(8'h00);
        lcheck("t2_done", done, 1'b1);
        lcheck("t2_crc_ok", crc_ok, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 9'd300);
        lcheck("t2_rd300", rd_data, 8'h2C);

        // Error token, token ignored afterwards
        do_clear();
        send(8'hFF);
        send(8'h09);
        lcheck("t3_error", {error, done, busy}, 3'b100);
        send(8'hFE);
        lcheck("t3_token_ignored", {error, busy}, 2'b10);

        // Timeout after the fourth filler byte, then recovery
        do_clear();
        repeat (3) send(8'hFF);
        lcheck("t4_no_err_3", error, 1'b0);
        send(8'hFF);
        lcheck("t4_err_4", error, 1'b1);
        send(8'hFF);
        do_clear();
        lcheck("t4_cleared", error, 1'b0);
        send(8'hFE);
        payload(3);
        c = crc_ref();
        send(c[15:8]);
        send(c[7:0]);
        lcheck("t4_done", {done, crc_ok, error}, 3'b110);

        // Abort mid-payload, then all-zero sector and a full back-to-back readout
        do_clear();
        send(8'hFE);
        repeat (100) send(8'($urandom_range(0, 255)));
        do_clear();
        send(8'hFE);
        payload(2);
        send(8'h00);
        send(8'h00);
        lcheck("t5_done", {done, crc_ok}, 2'b11);
        n_rd = 0;
        for (int a = 0; a < 512; a++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b1, 9'(a));
            if (rd_rdy && rd_data == 8'h00) n_rd++;
        end
        rcyc(1'b0, 8'h00, 1'b0);
        lcheck("t5_readout_count", 16'(n_rd), 16'd512);

        // Asynchronous reset mid-payload
        do_clear();
        send(8'hFE);
        repeat (50) send(8'h5A);
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        lcheck("rst_async", {rd_data, rd_rdy, done, crc_ok, error, busy}, 13'h0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // clear and gets together: clear wins, receiver is hunting again
        send(8'hFE);
        repeat (5) send(8'h33);
        rcyc(1'b1, 8'h44, 1'b1);
        lcheck("clear_wins", busy, 1'b0);
        send(8'h09);
        lcheck("hunting_after_clear", error, 1'b1);

        repeat (3) rcyc(1'b0, 8'h00, 1'b0);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", c_pass + l_pass, c_tot + l_tot);
        $finish;
    end

endmodule

// File: doc/sector_buffer.md
# sector_buffer

Receive-side stage directly downstream of the SD byte receiver. It consumes the byte stream produced during a CMD17 single-block read (byte strobe plus data byte), finds the start token and stores the 512-byte payload in internal RAM. It then checks the trailing CRC16 and serves random byte reads to the disk manager over a one-cycle request/response port.

## Interface
- TOKEN_TIMEOUT, default 1024: number of non-token bytes tolerated before the start token is declared missing.
- clk  in  1  system clock; all logic runs on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clear  in  1  one-cycle pulse; aborts any transfer and returns to WAIT_TOKEN. Driven from the same start strobes that reset the receiver.
- gets  in  1  one-cycle strobe: a new byte is valid on din.
- din  in  8  received byte.
- rd_start  in  1  one-cycle read request.
- rd_addr  in  9  byte index 0..511 for the read request.
- rd_data  out  8  read result; valid while rd_rdy=1.
- rd_rdy  out  1  one-cycle pulse, exactly 1 cycle after rd_start.
- done  out  1  level; sector received and CRC compared. Held until clear or rst.
- crc_ok  out  1  level; valid while done=1. 1 = received CRC equals the computed CRC.
- error  out  1  level; error token or timeout seen. Held until clear or rst.
- busy  out  1  level; 1 in DATA, CRC_HI and CRC_LO.

## Operation
- States: WAIT_TOKEN, DATA, CRC_HI, CRC_LO, DONE, ERR. Reset state is WAIT_TOKEN.
- WAIT_TOKEN, on each gets:
  - din=0xFE: go to DATA. Clear the byte counter and the CRC register (set to 0x0000).
  - din=0xFF: increment the timeout counter.
  - din[7:4]=0 and din[3:0]≠0 (SD data error token): go to ERR.
  - Any other value: increment the timeout counter.
  - Timeout counter reaching TOKEN_TIMEOUT: go to ERR.
- DATA, on each gets:
  - Write din to RAM[cnt].
  - Update the CRC with din.
  - Increment cnt (10-bit).
  - After the write at cnt=511, go to CRC_HI.
- CRC_HI, on gets: latch din as rx_crc[15:8], then go to CRC_LO.
- CRC_LO, on gets:
  - Latch din as rx_crc[7:0].
  - Go to DONE.
  - crc_ok = ({rx_crc[15:8], din} == crc_reg).
- DONE and ERR: stay until clear. Bytes arriving on gets are ignored.
- CRC: CRC16-CCITT/XMODEM, polynomial 0x1021, initial value 0x0000, MSB first, no final XOR. The 8-bit update is unrolled combinationally and applied in one cycle per byte.
- Read port:
  - rd_start with rd_addr samples RAM synchronously. rd_rdy pulses on the next cycle.
  - When the state is not DONE, rd_data=0x00 and rd_rdy still pulses.
  - rd_start is accepted every cycle; back-to-back reads give back-to-back rd_rdy.
- clear has priority over gets in the same cycle. It returns to WAIT_TOKEN, zeroes all counters and deasserts done, crc_ok and error. RAM contents are not cleared.
- gets and rd_start in the same cycle are independent: the RAM is dual-port, or the read is issued on a separate port.

## Timing
- Reset values:
  - rd_data=0x00, rd_rdy=0, done=0, crc_ok=0, error=0, busy=0.
  - State WAIT_TOKEN, cnt=0, timeout counter=0, crc_reg=0x0000, rx_crc=0x0000.
- The state changes on the edge that samples gets=1.
- busy rises 1 cycle after the gets carrying 0xFE.
- done and crc_ok are asserted 1 cycle after the gets carrying the CRC low byte.
- Read latency is exactly 1 cycle, with no stall.
- Transfer length: token + 512 data bytes + 2 CRC bytes = 515 strobed bytes. gets spacing is arbitrary (≥1 cycle).
- rst mid-transfer: asynchronous return to the reset values. A partial sector is never reported as done.

## Test plan
- Token 0xFE, 512×0xFF, then CRC bytes 0x7F, 0xA1 -> done=1 and crc_ok=1 one cycle after the last byte. Reading address 0 and address 511 both return 0xFF.
- Three 0xFF bytes, token 0xFE, bytes din=i[7:0] for i=0..511, then a deliberately wrong CRC 0x0000 -> done=1, crc_ok=0. Reading address 300 returns 0x2C.
- 0xFF, then error token 0x09 -> error=1, done=0, busy=0. A subsequent 0xFE is ignored until clear.
- TOKEN_TIMEOUT=4 with five 0xFF bytes -> error=1 after the fourth. Then clear followed by a valid sector -> done=1, error=0.
- clear pulsed after 100 data bytes, then a full valid all-0x00 sector with CRC 0x0000 -> done=1, crc_ok=1. Reading addresses 0..511 back-to-back gives 512 consecutive rd_rdy pulses, all data 0x00.
- rst asserted mid-DATA -> all outputs return to their reset values immediately. clear and gets asserted in the same cycle -> the state is WAIT_TOKEN.
